cohort_tri_arbiter: RTL and testbench

//  Multi-channel successor to the single-engine TRI hookup in the cohort tile wrapper. Round-robin arbitrates NUM_CH

---
 rtl/cohort_tri_pkg.sv | 33 +++
 rtl/cohort_tri_tag_fifo.sv | 55 +++++
 rtl/cohort_tri_arbiter.sv | 153 +++++++++++++++
 tb/tb_cohort_tri_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cohort_tri_pkg.sv
// Shared types and helpers for the cohort TRI arbiter: request bundle, field widths, byte swap.
package cohort_tri_pkg;

  localparam int unsigned TYPE_W  = 5;
  localparam int unsigned AMO_W   = 4;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned ADDR_W  = 40;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned RTYPE_W = 4;

  typedef struct packed {
    logic [TYPE_W-1:0] rqtype;
    logic [AMO_W-1:0]  amo_op;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } tri_req_t;

  function automatic logic [WORD_W-1:0] bswap64(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      r[8*(7-j) +: 8] = w[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] swap_words(input logic [DATA_W-1:0] d, input logic en);
    return en ? {bswap64(d[127:64]), bswap64(d[63:0])} : d;
  endfunction

endpackage

// File: rtl/cohort_tri_tag_fifo.sv
// In-order FIFO of channel IDs for TRI requests in flight; head is the owner of the next response.
module cohort_tri_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/cohort_tri_arbiter.sv
// Round-robin arbiter of NUM_CH engine channels onto one L1.5 TRI port, with in-order response routing.
module cohort_tri_arbiter
  import cohort_tri_pkg::*;
#(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SWAP_ENDIAN     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               ch_req_val,
  output logic [NUM_CH-1:0]               ch_req_rdy,
  input  logic [NUM_CH*TYPE_W-1:0]        ch_req_type,
  input  logic [NUM_CH*AMO_W-1:0]         ch_req_amo_op,
  input  logic [NUM_CH*SIZE_W-1:0]        ch_req_size,
  input  logic [NUM_CH*ADDR_W-1:0]        ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0]        ch_req_data,
  output logic [NUM_CH-1:0]               ch_resp_val,
  input  logic [NUM_CH-1:0]               ch_resp_rdy,
  output logic [RTYPE_W-1:0]              ch_resp_type,
  output logic                            ch_resp_atomic,
  output logic [DATA_W-1:0]               ch_resp_data,
  output logic                            tri_req_val,
  output logic [TYPE_W-1:0]               tri_req_rqtype,
  output logic [AMO_W-1:0]                tri_req_amo_op,
  output logic [SIZE_W-1:0]               tri_req_size,
  output logic [ADDR_W-1:0]               tri_req_address,
  output logic [WORD_W-1:0]               tri_req_data,
  output logic [WORD_W-1:0]               tri_req_data_next_entry,
  input  logic                            tri_req_ack,
  input  logic                            tri_resp_val,
  input  logic [RTYPE_W-1:0]              tri_resp_returntype,
  input  logic                            tri_resp_atomic,
  input  logic [WORD_W-1:0]               tri_resp_data_0,
  input  logic [WORD_W-1:0]               tri_resp_data_1,
  input  logic                            tri_resp_inval_val,
  output logic                            tri_resp_req_ack,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_cnt,
  output logic                            err_unexpected_resp
);

  localparam int unsigned TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic        SWAP  = (SWAP_ENDIAN != 0);

  tri_req_t         stg_q, req_d;
  logic             stg_val_q;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] gnt_id, cand, head;
  logic [TAG_W:0]   sum;
  logic             any_val, grant, fifo_full, fifo_empty, pop, err_q, err_set;

  // Scan channels starting at the pointer; the first valid one wins.
  always_comb begin
    any_val = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr_q} + (TAG_W+1)'(i);
      if (sum >= (TAG_W+1)'(NUM_CH)) sum = sum - (TAG_W+1)'(NUM_CH);
      cand = sum[TAG_W-1:0];
      if (!any_val && ch_req_val[cand]) begin
        any_val = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign grant = any_val && !fifo_full && (!stg_val_q || tri_req_ack);
  assign ptr_d = (gnt_id == TAG_W'(NUM_CH-1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    ch_req_rdy = '0;
    if (grant) ch_req_rdy = NUM_CH'(1) << gnt_id;
    req_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_id == TAG_W'(i)) begin
        req_d.rqtype = ch_req_type[i*TYPE_W +: TYPE_W];
        req_d.amo_op = ch_req_amo_op[i*AMO_W +: AMO_W];
        req_d.size   = ch_req_size[i*SIZE_W +: SIZE_W];
        req_d.addr   = ch_req_addr[i*ADDR_W +: ADDR_W];
        req_d.data   = swap_words(ch_req_data[i*DATA_W +: DATA_W], SWAP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_val_q <= 1'b0;
      stg_q     <= '0;
      ptr_q     <= '0;
    end else if (grant) begin
      stg_val_q <= 1'b1;
      stg_q     <= req_d;
      ptr_q     <= ptr_d;
    end else if (stg_val_q && tri_req_ack) begin
      stg_val_q <= 1'b0;
    end
  end

  assign tri_req_val             = stg_val_q;
  assign tri_req_rqtype          = stg_q.rqtype;
  assign tri_req_amo_op          = stg_q.amo_op;
  assign tri_req_size            = stg_q.size;
  assign tri_req_address         = stg_q.addr;
  assign tri_req_data            = stg_q.data[63:0];
  assign tri_req_data_next_entry = stg_q.data[127:64];

  cohort_tri_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .din_i   (gnt_id),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_cnt)
  );

  // Invalidations and orphan responses are swallowed so L1.5 never stalls on them.
  always_comb begin
    ch_resp_val      = '0;
    tri_resp_req_ack = 1'b0;
    pop              = 1'b0;
    err_set          = 1'b0;
    if (tri_resp_val) begin
      if (tri_resp_inval_val) begin
        tri_resp_req_ack = 1'b1;
      end else if (fifo_empty) begin
        tri_resp_req_ack = 1'b1;
        err_set          = 1'b1;
      end else begin
        ch_resp_val[head] = 1'b1;
        tri_resp_req_ack  = ch_resp_rdy[head];
        pop               = ch_resp_rdy[head];
      end
    end
  end

  assign ch_resp_type   = tri_resp_returntype;
  assign ch_resp_atomic = tri_resp_atomic;
  assign ch_resp_data   = swap_words({tri_resp_data_1, tri_resp_data_0}, SWAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_cohort_tri_arbiter.sv
// Self-checking bench for cohort_tri_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_cohort_tri_arbiter;

  localparam int NCH  = 2;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0]     ch_req_val, ch_req_rdy, ch_resp_val, ch_resp_rdy;
  logic [NCH*5-1:0]   ch_req_type;
  logic [NCH*4-1:0]   ch_req_amo_op;
  logic [NCH*3-1:0]   ch_req_size;
  logic [NCH*40-1:0]  ch_req_addr;
  logic [NCH*128-1:0] ch_req_data;
  logic [3:0]   ch_resp_type;
  logic         ch_resp_atomic;
  logic [127:0] ch_resp_data;
  logic         tri_req_val, tri_req_ack;
  logic [4:0]   tri_req_rqtype;
  logic [3:0]   tri_req_amo_op;
  logic [2:0]   tri_req_size;
  logic [39:0]  tri_req_address;
  logic [63:0]  tri_req_data, tri_req_data_next_entry;
  logic         tri_resp_val, tri_resp_atomic, tri_resp_inval_val, tri_resp_req_ack;
  logic [3:0]   tri_resp_returntype;
  logic [63:0]  tri_resp_data_0, tri_resp_data_1;
  logic [2:0]   outstanding_cnt;
  logic         err_unexpected_resp;

  always #5 clk = ~clk;

  cohort_tri_arbiter #(.NUM_CH(NCH), .MAX_OUTSTANDING(MAXO), .SWAP_ENDIAN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_val(ch_req_val), .ch_req_rdy(ch_req_rdy), .ch_req_type(ch_req_type),
    .ch_req_amo_op(ch_req_amo_op), .ch_req_size(ch_req_size), .ch_req_addr(ch_req_addr),
    .ch_req_data(ch_req_data), .ch_resp_val(ch_resp_val), .ch_resp_rdy(ch_resp_rdy),
    .ch_resp_type(ch_resp_type), .ch_resp_atomic(ch_resp_atomic), .ch_resp_data(ch_resp_data),
    .tri_req_val(tri_req_val), .tri_req_rqtype(tri_req_rqtype), .tri_req_amo_op(tri_req_amo_op),
    .tri_req_size(tri_req_size), .tri_req_address(tri_req_address), .tri_req_data(tri_req_data),
    .tri_req_data_next_entry(tri_req_data_next_entry), .tri_req_ack(tri_req_ack),
    .tri_resp_val(tri_resp_val), .tri_resp_returntype(tri_resp_returntype),
    .tri_resp_atomic(tri_resp_atomic), .tri_resp_data_0(tri_resp_data_0),
    .tri_resp_data_1(tri_resp_data_1), .tri_resp_inval_val(tri_resp_inval_val),
    .tri_resp_req_ack(tri_resp_req_ack), .outstanding_cnt(outstanding_cnt),
    .err_unexpected_resp(err_unexpected_resp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: staged request, queue of in-flight channel IDs, RR pointer, sticky error.
  bit           m_sv;
  logic [4:0]   m_type;
  logic [3:0]   m_amo;
  logic [2:0]   m_size;
  logic [39:0]  m_addr;
  logic [127:0] m_data;
  int           m_q[$];
  int           m_ptr;
  bit           m_err;

  logic [NCH-1:0] o_rdy, o_rv;
  logic           o_ack, o_tv;
  logic [63:0]    o_dlo;
  logic [39:0]    o_addr;
  logic [127:0]   o_rdata;
  int             last_g;

  function automatic logic [63:0] bsw(input logic [63:0] w);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*(7-j) +: 8] = w[8*j +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, ch_req_rdy, 0);
    check({tag, "_rv"}, ch_resp_val, 0);
    check({tag, "_rtype"}, {ch_resp_atomic, ch_resp_type}, 0);
    check({tag, "_rdata"}, ch_resp_data, 0);
    check({tag, "_tval"}, tri_req_val, 0);
    check({tag, "_treq"}, {tri_req_rqtype, tri_req_amo_op, tri_req_size, tri_req_address}, 0);
    check({tag, "_tdata"}, {tri_req_data_next_entry, tri_req_data}, 0);
    check({tag, "_ack"}, tri_resp_req_ack, 0);
    check({tag, "_cnt"}, outstanding_cnt, 0);
    check({tag, "_err"}, err_unexpected_resp, 0);
  endtask

  task automatic model_reset();
    m_sv = 0; m_q.delete(); m_ptr = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    ch_req_val = '0; ch_resp_rdy = '0; tri_req_ack = 0; tri_resp_val = 0; tri_resp_inval_val = 0;
    tri_resp_returntype = '0; tri_resp_atomic = 0; tri_resp_data_0 = '0; tri_resp_data_1 = '0;
    ch_req_type = '0; ch_req_amo_op = '0; ch_req_size = '0; ch_req_addr = '0; ch_req_data = '0;
  endtask

  task automatic rand_fields();
    for (int c = 0; c < NCH; c++) begin
      ch_req_type[c*5 +: 5]     = 5'($urandom);
      ch_req_amo_op[c*4 +: 4]   = 4'($urandom);
      ch_req_size[c*3 +: 3]     = 3'($urandom);
      ch_req_addr[c*40 +: 40]   = 40'({$urandom, $urandom});
      ch_req_data[c*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    end
    tri_resp_returntype = 4'($urandom);
    tri_resp_atomic     = 1'($urandom);
    tri_resp_data_0     = {$urandom, $urandom};
    tri_resp_data_1     = {$urandom, $urandom};
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model on the edge.
  task automatic cycle();
    int g, c, h;
    logic [NCH-1:0] erdy, erv;
    logic eack;
    bit pop, eset;
    logic [4:0] cty; logic [3:0] cam; logic [2:0] csz; logic [39:0] cad; logic [127:0] cdt;
    #1;
    g = -1;
    if ((!m_sv || tri_req_ack) && m_q.size() < MAXO)
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && ch_req_val[c]) g = c;
      end
    erdy = '0;
    if (g >= 0) begin
      erdy[g] = 1'b1;
      cty = ch_req_type[g*5 +: 5]; cam = ch_req_amo_op[g*4 +: 4]; csz = ch_req_size[g*3 +: 3];
      cad = ch_req_addr[g*40 +: 40];
      cdt = ch_req_data[g*128 +: 128];
    end
    erv = '0; eack = 0; pop = 0; eset = 0;
    if (tri_resp_val) begin
      if (tri_resp_inval_val) eack = 1;
      else if (m_q.size() == 0) begin eack = 1; eset = 1; end
      else begin h = m_q[0]; erv[h] = 1'b1; eack = ch_resp_rdy[h]; pop = eack; end
    end
    check("req_rdy", ch_req_rdy, erdy);
    check("tri_val", tri_req_val, m_sv);
    if (m_sv) begin
      check("tri_fields", {tri_req_rqtype, tri_req_amo_op, tri_req_size, tri_req_address},
            {m_type, m_amo, m_size, m_addr});
      check("tri_data", {tri_req_data_next_entry, tri_req_data}, m_data);
    end
    check("cnt", outstanding_cnt, m_q.size());
    check("err", err_unexpected_resp, m_err);
    check("resp_val", ch_resp_val, erv);
    check("resp_ack", tri_resp_req_ack, eack);
    check("resp_meta", {ch_resp_atomic, ch_resp_type}, {tri_resp_atomic, tri_resp_returntype});
    check("resp_data", ch_resp_data, {bsw(tri_resp_data_1), bsw(tri_resp_data_0)});
    o_rdy = ch_req_rdy; o_rv = ch_resp_val; o_ack = tri_resp_req_ack; o_tv = tri_req_val;
    o_dlo = tri_req_data; o_addr = tri_req_address; o_rdata = ch_resp_data;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (eset) m_err = 1;
    if (m_sv && tri_req_ack) m_sv = 0;
    if (g >= 0) begin
      m_sv = 1; m_type = cty; m_amo = cam; m_size = csz; m_addr = cad;
      m_data = {bsw(cdt[127:64]), bsw(cdt[63:0])};
      m_q.push_back(g);
      m_ptr = (g + 1) % NCH;
    end
    last_g = g;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    ch_req_val = '0; tri_req_ack = 1; tri_resp_val = 1; tri_resp_inval_val = 0; ch_resp_rdy = '1;
    n = 0;
    while (m_q.size() > 0 && n < 20) begin rand_fields(); cycle(); n++; end
    idle_inputs();
    tri_req_ack = 1;
    cycle();
    check("drain_cnt", outstanding_cnt, 0);
  endtask

  initial begin
    int gs[4];
    idle_inputs();
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1;

    // Two channels competing, ack always high: alternating grants, then the FIFO fills.
    rand_fields();
    ch_req_val = 2'b11; tri_req_ack = 1;
    for (int i = 0; i < 4; i++) begin cycle(); gs[i] = last_g; end
    check("t1_order", {8'(gs[0]), 8'(gs[1]), 8'(gs[2]), 8'(gs[3])}, 32'h00010001);
    cycle();
    check("t1_tval_steady", o_tv, 1);
    check("t3_full_rdy", o_rdy, 2'b00);
    check("t3_full_cnt", outstanding_cnt, 4);
    tri_resp_val = 1; ch_resp_rdy = 2'b11;
    cycle();
    check("t3_rdy_held", o_rdy, 2'b00);
    tri_resp_val = 0;
    cycle();
    check("t3_rdy_back", o_rdy, 2'b01);
    drain();

    // Byte swap on the request path.
    rand_fields();
    ch_req_val = 2'b10;
    ch_req_addr[40 +: 40] = 40'h40;
    ch_req_data[128 +: 64] = 64'h0011223344556677;
    cycle();
    check("t2_grant", last_g, 1);
    ch_req_val = '0;
    cycle();
    check("t2_data", o_dlo, 64'h7766554433221100);
    check("t2_addr", o_addr, 40'h40);
    drain();

    // Responses routed in issue order; an invalidation in the stream is dropped.
    tri_req_ack = 1;
    ch_req_val = 2'b01; cycle(); gs[0] = last_g;
    ch_req_val = 2'b10; cycle(); gs[1] = last_g;
    ch_req_val = 2'b01; cycle(); gs[2] = last_g;
    check("t4_issue", {8'(gs[0]), 8'(gs[1]), 8'(gs[2])}, 24'h000100);
    ch_req_val = '0; tri_resp_val = 1; ch_resp_rdy = 2'b11;
    cycle(); check("t4_r0", {o_rv, o_ack}, {2'b01, 1'b1});
    tri_resp_inval_val = 1;
    cycle(); check("t4_inval", {o_rv, o_ack}, {2'b00, 1'b1});
    tri_resp_inval_val = 0;
    cycle(); check("t4_r1", o_rv, 2'b10);
    cycle(); check("t4_r2", o_rv, 2'b01);
    tri_resp_val = 0;
    cycle(); check("t4_cnt", outstanding_cnt, 0);

    // Backpressure from the head channel holds the response.
    ch_req_val = 2'b10; cycle();
    check("t5_grant", last_g, 1);
    ch_req_val = '0; tri_resp_val = 1; ch_resp_rdy = 2'b01;
    tri_resp_data_0 = 64'h0102030405060708; tri_resp_data_1 = 64'h1112131415161718;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_hold", {o_rv, o_ack}, {2'b10, 1'b0});
    end
    ch_resp_rdy = 2'b11;
    cycle();
    check("t5_release", o_ack, 1);
    check("t5_data", o_rdata, 128'h18171615141312110807060504030201);

    // Orphan response, then reset in the middle of a burst.
    tri_resp_val = 1; ch_resp_rdy = '0;
    cycle();
    check("t6_orphan_ack", o_ack, 1);
    tri_resp_val = 0;
    cycle();
    check("t6_err", err_unexpected_resp, 1);
    ch_req_val = 2'b11;
    for (int i = 0; i < 5; i++) begin rand_fields(); tri_req_ack = 1'($urandom); cycle(); end
    idle_inputs();
    rst_n = 0;
    #2;
    check_all_zero("midrst");
    #1;
    rst_n = 1;
    model_reset();
    @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_fields();
      ch_req_val         = NCH'($urandom);
      tri_req_ack        = ($urandom % 4) != 0;
      ch_resp_rdy        = NCH'($urandom);
      tri_resp_val       = ($urandom % 10) < 4;
      tri_resp_inval_val = ($urandom % 6) == 0;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
